// File: rtl/bitwise_pipe.sv
// Pipelined bitwise ALU with valid/ready flow control; result computed in stage 1, later stages only carry it.
// Optional BITWISE_PIPE_POPCNT_EN adds an out_popcnt output counting the ones in out_data.
module bitwise_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             busy
`ifdef BITWISE_PIPE_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

    logic [STAGES-1:0] vld_q, vld_d, adv;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];
    logic              accept;
    logic              hole;

    function automatic logic [WIDTH-1:0] bit_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    // Walk from the output back: a stage advances if any later slot is empty or the consumer takes.
    always_comb begin
        adv  = '0;
        hole = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = vld_q[i] & hole;
            hole   = hole | ~vld_q[i];
        end
        in_ready = hole;
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        tag_d     = tag_q;
        vld_d[0]  = (vld_q[0] & ~adv[0]) | accept;
        if (accept) begin
            data_d[0] = bit_op(in_op, in_a, in_b);
            tag_d[0]  = in_tag;
        end
        for (int i = 1; i < STAGES; i++) begin
            vld_d[i] = (vld_q[i] & ~adv[i]) | adv[i-1];
            if (adv[i-1]) begin
                data_d[i] = data_q[i-1];
                tag_d[i]  = tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_zero  = ~|data_q[STAGES-1];
    assign busy      = |vld_q;

`ifdef BITWISE_PIPE_POPCNT_EN
    localparam int PW = $clog2(WIDTH + 1);

    always_comb begin
        out_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_popcnt = out_popcnt + PW'(data_q[STAGES-1][i]);
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_pipe.sv
// Scoreboard bench for bitwise_pipe: three instances (STAGES 1, 2, 4) each with directed and random traffic.
module tb_bitwise_pipe;
    localparam int W  = 16;
    localparam int TW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    bit done [3];

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
        int            acc;
        bit            lat;
    } ent_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~(a & b);
            4: r = ~(a | b);
            5: r = ~(a ^ b);
            6: r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_pipe
        localparam int STG = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        logic          rst, in_valid, in_ready, out_valid, out_ready, out_zero, busy;
        logic [2:0]    in_op;
        logic [W-1:0]  in_a, in_b, out_data;
        logic [TW-1:0] in_tag, out_tag;
`ifdef BITWISE_PIPE_POPCNT_EN
        logic [4:0]    out_popcnt;
`endif

        bitwise_pipe #(.WIDTH(W), .STAGES(STG), .TAG_W(TW)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
            .out_tag(out_tag), .out_zero(out_zero), .busy(busy)
`ifdef BITWISE_PIPE_POPCNT_EN
            , .out_popcnt(out_popcnt)
`endif
        );

        ent_t q[$];
        bit   rdy_rand = 1'b0;
        logic rdy_hold = 1'b1;
        logic prev_stall = 1'b0;
        logic [W-1:0]  prev_d;
        logic [TW-1:0] prev_t;

        initial begin
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #2;
                out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
            end
        end

        // Monitor: compare every delivered result against the head of the queue.
        initial begin
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (prev_stall) begin
                        check($sformatf("S%0d hold_valid", STG), out_valid, 1);
                        check($sformatf("S%0d hold_data", STG), out_data, prev_d);
                        check($sformatf("S%0d hold_tag", STG), out_tag, prev_t);
                    end
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            check($sformatf("S%0d spurious_valid", STG), out_valid, 0);
                        end else begin
                            ent_t e;
                            e = q.pop_front();
                            check($sformatf("S%0d data", STG), out_data, e.d);
                            check($sformatf("S%0d tag", STG), out_tag, e.t);
                            check($sformatf("S%0d zero", STG), out_zero, (e.d == '0));
`ifdef BITWISE_PIPE_POPCNT_EN
                            check($sformatf("S%0d popcnt", STG), out_popcnt, $countones(e.d));
`endif
                            if (e.lat) check($sformatf("S%0d latency", STG), cyc - e.acc, STG);
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_d     = out_data;
                    prev_t     = out_tag;
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end

        task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [TW-1:0] t, input logic [W-1:0] exp, input bit lat);
            int n = 0;
            in_valid = 1'b1;
            in_op = op; in_a = a; in_b = b; in_tag = t;
            forever begin
                @(negedge clk);
                if (in_ready) begin
                    q.push_back('{d: exp, t: t, acc: cyc, lat: lat});
                    break;
                end
                n++;
                if (n > 200) begin
                    check($sformatf("S%0d accept_timeout", STG), in_ready, 1);
                    break;
                end
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_op = 3'($urandom); in_a = W'($urandom); in_b = W'($urandom); in_tag = TW'($urandom);
        endtask

        task automatic send_rand(input bit lat);
            logic [2:0]    op;
            logic [W-1:0]  a, b;
            logic [TW-1:0] t;
            op = 3'($urandom_range(0, 7));
            a = W'($urandom); b = W'($urandom); t = TW'($urandom);
            send(op, a, b, t, ref_op(int'(op), a, b), lat);
        endtask

        task automatic idle_gap();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic wait_drain();
            int n = 0;
            while (q.size() != 0 && n < 500) begin
                @(posedge clk);
                n++;
                if (q.size() == 0 || n >= 500) #1;
            end
            check($sformatf("S%0d drain", STG), q.size(), 0);
        endtask

        initial begin
            rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
            #12;
            check($sformatf("S%0d rst_out_valid", STG), out_valid, 0);
            check($sformatf("S%0d rst_busy", STG), busy, 0);
            check($sformatf("S%0d rst_out_data", STG), out_data, 0);
            check($sformatf("S%0d rst_out_tag", STG), out_tag, 0);
            check($sformatf("S%0d rst_out_zero", STG), out_zero, 1);
`ifdef BITWISE_PIPE_POPCNT_EN
            check($sformatf("S%0d rst_popcnt", STG), out_popcnt, 0);
`endif
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("S%0d ready_after_rst", STG), in_ready, 1);

            send(3'd0, 16'h0080, 16'h4922, 2'd1, 16'h0000, 1'b1);
            send(3'd1, 16'h8101, 16'h2441, 2'd0, 16'hA541, 1'b1);
            send(3'd2, 16'h8101, 16'h2441, 2'd1, 16'hA540, 1'b1);
            send(3'd3, 16'h8101, 16'h2441, 2'd2, 16'hFFFE, 1'b1);
            wait_drain();

            // Fill with the consumer stalled, then offer one more that must wait.
            rdy_hold = 1'b0;
            for (int i = 0; i < STG; i++) send_rand(1'b0);
            fork
                send_rand(1'b0);
                begin
                    repeat (5) begin
                        @(negedge clk);
                        check($sformatf("S%0d stall_in_ready", STG), in_ready, 0);
                        check($sformatf("S%0d stall_busy", STG), busy, 1);
                    end
                    @(posedge clk);
                    #1;
                    rdy_hold = 1'b1;
                end
            join
            wait_drain();

            // Reset with entries in flight; none may come out afterwards.
            send_rand(1'b0);
            send_rand(1'b0);
            #1;
            rst = 1'b1;
            #1;
            check($sformatf("S%0d midrst_out_valid", STG), out_valid, 0);
            check($sformatf("S%0d midrst_busy", STG), busy, 0);
            check($sformatf("S%0d midrst_out_data", STG), out_data, 0);
            check($sformatf("S%0d midrst_out_zero", STG), out_zero, 1);
            q.delete();
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("S%0d ready_after_midrst", STG), in_ready, 1);
            repeat (STG + 2) begin
                @(negedge clk);
                check($sformatf("S%0d no_stale", STG), out_valid, 0);
            end
            @(posedge clk);
            #1;
            send(3'd5, 16'h8101, 16'h2441, 2'd3, 16'h5ABF, 1'b1);
            wait_drain();

            rdy_rand = 1'b1;
            repeat (60) begin
                idle_gap();
                send_rand(1'b0);
            end
            wait_drain();

            rdy_rand = 1'b0;
            rdy_hold = 1'b1;
            repeat (30) begin
                idle_gap();
                send_rand(1'b1);
            end
            wait_drain();
            done[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done[0] && done[1] && done[2]);
            #200000;
        join_any
        check("all_instances_done", {done[0], done[1], done[2]}, 3'b111);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bitwise_pipe.md
BITWISE_PIPE -- requirements
Module: bitwise_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 1..64).
REQ-002 SHALL have parameter STAGES, default 2, giving the pipeline depth in cycles (legal range 1..4).
REQ-003 SHALL have parameter TAG_W, default 2, giving the width of the caller tag carried alongside each operation.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the offered operation this cycle.
REQ-008 SHALL have port in_op, input, 3 bits: operation select.
REQ-009 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-010 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-011 SHALL have port in_tag, input, TAG_W bits: caller tag, returned unmodified with the result.
REQ-012 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer takes the presented result this cycle.
REQ-014 SHALL have port out_data, output, WIDTH bits: the result.
REQ-015 SHALL have port out_tag, output, TAG_W bits: the tag of the presented result.
REQ-016 SHALL have port out_zero, output, 1 bit: high when out_data is all zeros.
REQ-017 SHALL have port busy, output, 1 bit: high when any pipeline stage holds a valid entry.

Function
REQ-018 SHALL decode in_op as follows: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A AND NOT B, 7 pass A.
REQ-019 SHALL accept an operation on a cycle where in_valid and in_ready are both high; no other cycle accepts.
REQ-020 SHALL compute the result and register it into stage 1 on the accept edge; stages 2..STAGES only carry data, tag and valid forward.
REQ-021 SHALL raise out_valid exactly STAGES cycles after the accept edge when out_ready is held high (latency STAGES).
REQ-022 SHALL sustain one accept and one delivery per cycle when out_ready is held high.
REQ-023 SHALL advance each stage when its successor is empty or is itself advancing; the last stage advances when out_ready is high.
REQ-024 SHALL drive in_ready high when stage 1 is empty or stage 1 advances this cycle, so a full pipeline with out_ready high still accepts.
REQ-025 SHALL hold out_data, out_tag and out_zero stable while out_valid is high and out_ready is low.
REQ-026 SHALL never drop, duplicate or reorder entries; results leave in accept order with their tags.
REQ-027 SHALL allow in_valid to drop without an accept and in_op, in_a, in_b and in_tag to change while in_ready is low, with no effect on state.
REQ-028 SHALL ignore out_ready while out_valid is low.
REQ-029 SHALL compute out_zero from the registered result, aligned with out_data.
REQ-030 SHALL evaluate the combinational in_ready path from out_ready through all stages within a single cycle.

Reset
REQ-031 SHALL, on rst high, immediately clear all stage valid bits, giving out_valid=0 and busy=0.
REQ-032 SHALL, on rst high, force out_data=0, out_tag=0 and out_zero=1.
REQ-033 SHALL discard in-flight entries on a reset asserted mid-operation; they are never delivered.
REQ-034 SHALL have in_ready=1 from the first clock edge after rst deasserts.

Configuration
REQ-035 SHALL, with macro BITWISE_PIPE_POPCNT_EN defined, add output out_popcnt, width $clog2(WIDTH+1), holding the number of ones in out_data, aligned with out_data, with reset value 0.
REQ-036 SHALL, without BITWISE_PIPE_POPCNT_EN, have no out_popcnt port and no popcount logic; all other behaviour is identical.

Verification
REQ-037 Bench SHALL drive WIDTH=16, STAGES=2, op=0, A=0x0080, B=0x4922, tag=1 with out_ready=1 -> two cycles later out_data=0x0000, out_zero=1, out_tag=1.
REQ-038 Bench SHALL drive back-to-back ops 1, 2 and 3 on A=0x8101, B=0x2441 with tags 0, 1, 2 -> results 0xA541, 0xA540 and 0xFFFE on consecutive cycles, in tag order.
REQ-039 Bench SHALL fill the pipeline and hold out_ready=0 for 5 cycles -> in_ready=0 once both stages are full, outputs stable throughout, then all 3 results delivered in order after release.
REQ-040 Bench SHALL assert rst while 2 entries are in flight -> out_valid=0 and busy=0 immediately, no stale result afterwards, and the next op completes normally.
REQ-041 Bench SHALL, with BITWISE_PIPE_POPCNT_EN defined, drive op=1 on A=0x8101, B=0x2441 -> out_data=0xA541, out_popcnt=6.
REQ-042 Bench SHALL sweep STAGES=1 and STAGES=4 with random ops and random out_ready -> every result matches the reference model and latency equals STAGES under no stall.
